operand_gather: RTL and testbench

OPERAND_GATHER -- requirements
Module: operand_gather

---
 rtl/operand_gather.sv | 86 ++++++++
 tb/tb_operand_gather.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/operand_gather.sv
// Collects up to NB_INS operand words into one group for a downstream AND stage.
// A short group (in_last early) is padded with all-ones. Output is registered; the block stalls upstream while a group is held.
module operand_gather #(
    parameter int BUS_WIDTH = 4,
    parameter int NB_INS    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BUS_WIDTH-1:0]          in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BUS_WIDTH*NB_INS-1:0]   out_buses,
    output logic [$clog2(NB_INS+1)-1:0]   count
);

    localparam int CW = $clog2(NB_INS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NB_INS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NB_INS);

    typedef enum logic {FILL, FULL} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [BUS_WIDTH*NB_INS-1:0]   slots_q, slots_d;
    logic                          accept;

    assign accept = in_valid && (state_q == FILL);

    // Slots above count_q are already all-ones (set on reset and on every
    // group release), so an early in_last needs no explicit padding.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        slots_d = slots_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < NB_INS; k++) begin
                        if (CW'(k) == count_q) begin
                            slots_d[k*BUS_WIDTH +: BUS_WIDTH] = in_data;
                        end
                    end
                    if (in_last || (count_q == LAST_IDX)) begin
                        count_d = FULL_CNT;
                        state_d = FULL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    slots_d = '1;
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
                slots_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
            slots_q <= '1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            slots_q <= slots_d;
        end
    end

    assign in_ready  = (state_q == FILL) && !rst;
    assign out_valid = (state_q == FULL);
    assign out_buses = slots_q;
    assign count     = count_q;

endmodule

// File: tb/tb_operand_gather.sv
// Randomized and directed bench for operand_gather against a queue-based group model.
module tb_operand_gather;

    localparam int BW = 4;
    localparam int NB = 3;
    localparam int CW = $clog2(NB + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [BW-1:0]       in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [BW*NB-1:0]    out_buses;
    logic [CW-1:0]       count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: words of the group being collected, and whether it is complete.
    logic [BW-1:0] grp[$];
    bit            m_full;

    always #5 clk = ~clk;

    operand_gather #(.BUS_WIDTH(BW), .NB_INS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_buses (out_buses),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BW*NB-1:0] model_bus();
        logic [BW*NB-1:0] b;
        b = '1;
        foreach (grp[i]) b[i*BW +: BW] = grp[i];
        return b;
    endfunction

    function automatic logic [BW-1:0] and_of(input logic [BW*NB-1:0] b);
        logic [BW-1:0] a;
        a = '1;
        for (int i = 0; i < NB; i++) a = a & b[i*BW +: BW];
        return a;
    endfunction

    task automatic check_outputs();
        check("in_ready",  in_ready,  !m_full);
        check("out_valid", out_valid, m_full);
        check("count",     count,     m_full ? NB : grp.size());
        check("out_buses", out_buses, model_bus());
    endtask

    // Called at a negedge: drive, check, take one rising edge, advance model.
    task automatic step(input bit v, input logic [BW-1:0] d, input bit l, input bit ordy);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #1;
        check_outputs();
        @(posedge clk);
        if (m_full) begin
            if (ordy) begin
                m_full = 1'b0;
                grp.delete();
            end
        end else if (v) begin
            grp.push_back(d);
            if (l || grp.size() == NB) m_full = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_count",     count,     0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_buses", out_buses, {BW*NB{1'b1}});
        grp.delete();
        m_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        m_full = 1'b0;
        #1;
        check("init_count",     count,     0);
        check("init_out_valid", out_valid, 0);
        check("init_in_ready",  in_ready,  0);
        check("init_out_buses", out_buses, {BW*NB{1'b1}});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Three-word group, then consume it.
        step(1, 4'b1101, 0, 1);
        step(1, 4'b1011, 0, 1);
        step(1, 4'b1111, 0, 1);
        #1;
        check("s1_bus", out_buses, 12'b1111_1011_1101);
        check("s1_and", and_of(out_buses), 4'b1001);
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 0);

        // Single word with in_last.
        step(1, 4'b0110, 1, 0);
        #1;
        check("s2_bus",   out_buses, 12'b1111_1111_0110);
        check("s2_count", count, 3);
        // Held for five cycles with in_valid still asserted.
        for (int i = 0; i < 5; i++) step(1, 4'(i), i[0], 0);
        check("s3_bus_held", out_buses, 12'b1111_1111_0110);
        step(1, 4'h2, 0, 1);

        // Reset after two words, then a fresh group.
        step(1, 4'h3, 0, 0);
        step(1, 4'h4, 0, 0);
        pulse_reset();
        step(1, 4'h5, 0, 0);
        step(1, 4'h6, 0, 0);
        step(1, 4'h7, 0, 0);
        #1;
        check("s4_bus", out_buses, 12'h765);
        step(0, 4'h0, 0, 1);

        // Back-to-back groups with valid and ready held high.
        for (int i = 0; i < 4 * (NB + 1); i++) step(1, 4'($urandom), 0, 1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1);
        end

        #1;
        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
